uart_rx: RTL and testbench

- UART receiver, 8N1, LSB first; counterpart of the board's existing txd transmitter.
- Sits in the memory-mapped I/O bus beside the transmitter.
- Synchronises the board rxd pin, deserialises frames by mid-bit sampling, and holds one received byte until the CPU acknowledges it.
- Reports framing errors and overruns.

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 137 +++++++++++++
 tb/tb_uart_rx.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the existing transmitter.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous board input.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a one-byte holding register
// and sticky framing/overrun flags.
//
// state | meaning
// IDLE  | line idle, waiting for rxs low
// START | timing to the middle of the start bit, rejecting glitches
// DATA  | sampling eight data bits, LSB first, one per bit period
// STOP  | sampling the stop bit and loading the holding register
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int IW           = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_START = 2'(START);
    localparam logic [1:0] S_DATA  = 2'(DATA);
    localparam logic [1:0] S_STOP  = 2'(STOP);

    logic                 rxs;
    logic [1:0]           state;
    logic [CW-1:0]        clk_cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 stop_load;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rxd),
        .q    (rxs)
    );

    assign stop_load = (state == S_STOP) && (clk_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    clk_cnt <= '0;
                    if (!rxs) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (clk_cnt == CNT_HALF) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        // A start bit that has gone high again by mid-bit was noise.
                        state   <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        shift   <= {rxs, shift[DATA_BITS-1:1]};
                        if (bit_idx == IDX_LAST) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                default: begin
                    clk_cnt <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    // Error sets are written after the clear so a coincident event wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (err_clr) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end
            if (stop_load) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
                if (!rxs) begin
                    frame_err <= 1'b1;
                end
                if (rx_valid && !rx_ack) begin
                    overrun <= 1'b1;
                end
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are driven at bit level and the
// outputs are compared against a byte-level model of the holding register.
module tb_uart_rx;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ack = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_data = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_ferr = 1'b0;
    logic       exp_ovr = 1'b0;

    uart_rx #(
        .CLK_FREQ (1_000_000),
        .BAUD_RATE(100_000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ack   (rx_ack),
        .frame_err(frame_err),
        .overrun  (overrun),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Byte-level model of the receiver's visible registers.
    task automatic model_frame(input logic [7:0] b, input logic stop, input logic ack_at_load);
        if (exp_valid && !ack_at_load) exp_ovr = 1'b1;
        if (!stop) exp_ferr = 1'b1;
        exp_data  = b;
        exp_valid = 1'b1;
    endtask

    task automatic model_reset();
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    // Callers sit on a negedge; the start bit begins at that instant.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rxd   = 1'b1;
        repeat (4) @(negedge clk);
        model_reset();
        checks++;
        if ({rx_valid, rx_data, frame_err, overrun} !== {exp_valid, exp_data, exp_ferr, exp_ovr}) begin
            failures++;
            $display("FAIL reset: got v/d/fe/ov=%0b/%02h/%0b/%0b want %0b/%02h/%0b/%0b",
                     rx_valid, rx_data, frame_err, overrun, exp_valid, exp_data, exp_ferr, exp_ovr);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        int lat = -1;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int n = 1; n <= 150; n++) begin
                    @(negedge clk);
                    if (rx_valid === 1'b1) begin
                        lat = n;
                        break;
                    end
                end
            end
        join
        model_frame(8'hA5, 1'b1, 1'b0);
        checks++;
        if (lat < 96 || lat > 98) begin
            failures++;
            $display("FAIL latency: got %0d cycles want 96..98", lat);
        end
        checks++;
        if ({rx_valid, rx_data, frame_err, overrun} !== {exp_valid, exp_data, exp_ferr, exp_ovr}) begin
            failures++;
            $display("FAIL basic_a5: got v/d/fe/ov=%0b/%02h/%0b/%0b want %0b/%02h/%0b/%0b",
                     rx_valid, rx_data, frame_err, overrun, exp_valid, exp_data, exp_ferr, exp_ovr);
        end
        pulse_ack();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        fork
            begin
                send_frame(8'h3C, 1'b1);
                send_frame(8'hC3, 1'b1);
            end
            begin
                repeat (99) @(negedge clk);
                model_frame(8'h3C, 1'b1, 1'b0);
                checks++;
                if ({rx_valid, rx_data, frame_err, overrun} !== {exp_valid, exp_data, exp_ferr, exp_ovr}) begin
                    failures++;
                    $display("FAIL b2b_first: got v/d/fe/ov=%0b/%02h/%0b/%0b want %0b/%02h/%0b/%0b",
                             rx_valid, rx_data, frame_err, overrun, exp_valid, exp_data, exp_ferr, exp_ovr);
                end
                pulse_ack();
            end
        join
        model_frame(8'hC3, 1'b1, 1'b0);
        checks++;
        if ({rx_valid, rx_data, frame_err, overrun} !== {exp_valid, exp_data, exp_ferr, exp_ovr}) begin
            failures++;
            $display("FAIL b2b_second: got v/d/fe/ov=%0b/%02h/%0b/%0b want %0b/%02h/%0b/%0b",
                     rx_valid, rx_data, frame_err, overrun, exp_valid, exp_data, exp_ferr, exp_ovr);
        end
        pulse_ack();
        repeat (3) @(negedge clk);

        send_frame(8'h3C, 1'b1);
        model_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1);
        model_frame(8'hC3, 1'b1, 1'b0);
        checks++;
        if ({rx_valid, rx_data, frame_err, overrun} !== {exp_valid, exp_data, exp_ferr, exp_ovr}) begin
            failures++;
            $display("FAIL overrun_set: got v/d/fe/ov=%0b/%02h/%0b/%0b want %0b/%02h/%0b/%0b",
                     rx_valid, rx_data, frame_err, overrun, exp_valid, exp_data, exp_ferr, exp_ovr);
        end
        pulse_clr();
        checks++;
        if ({rx_valid, rx_data, frame_err, overrun} !== {exp_valid, exp_data, exp_ferr, exp_ovr}) begin
            failures++;
            $display("FAIL overrun_clr: got v/d/fe/ov=%0b/%02h/%0b/%0b want %0b/%02h/%0b/%0b",
                     rx_valid, rx_data, frame_err, overrun, exp_valid, exp_data, exp_ferr, exp_ovr);
        end
        pulse_ack();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_frame_err();
        send_frame(8'h55, 1'b0);
        model_frame(8'h55, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        checks++;
        if ({rx_valid, rx_data, frame_err, overrun} !== {exp_valid, exp_data, exp_ferr, exp_ovr}) begin
            failures++;
            $display("FAIL frame_err: got v/d/fe/ov=%0b/%02h/%0b/%0b want %0b/%02h/%0b/%0b",
                     rx_valid, rx_data, frame_err, overrun, exp_valid, exp_data, exp_ferr, exp_ovr);
        end
        pulse_ack();
        pulse_clr();
        checks++;
        if ({rx_valid, rx_data, frame_err, overrun} !== {exp_valid, exp_data, exp_ferr, exp_ovr}) begin
            failures++;
            $display("FAIL ferr_clr: got v/d/fe/ov=%0b/%02h/%0b/%0b want %0b/%02h/%0b/%0b",
                     rx_valid, rx_data, frame_err, overrun, exp_valid, exp_data, exp_ferr, exp_ovr);
        end
        // A line held low for one frame time reads as 0x00 with a bad stop bit.
        rxd = 1'b0;
        repeat (10 * CPB) @(negedge clk);
        rxd = 1'b1;
        model_frame(8'h00, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        checks++;
        if ({rx_valid, rx_data, frame_err, overrun} !== {exp_valid, exp_data, exp_ferr, exp_ovr}) begin
            failures++;
            $display("FAIL break: got v/d/fe/ov=%0b/%02h/%0b/%0b want %0b/%02h/%0b/%0b",
                     rx_valid, rx_data, frame_err, overrun, exp_valid, exp_data, exp_ferr, exp_ovr);
        end
        pulse_ack();
        pulse_clr();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_glitch();
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (120) @(negedge clk);
        checks++;
        if ({rx_valid, rx_data, frame_err, overrun} !== {exp_valid, exp_data, exp_ferr, exp_ovr}) begin
            failures++;
            $display("FAIL glitch: got v/d/fe/ov=%0b/%02h/%0b/%0b want %0b/%02h/%0b/%0b",
                     rx_valid, rx_data, frame_err, overrun, exp_valid, exp_data, exp_ferr, exp_ovr);
        end
    endtask

    task automatic test_reset_midframe();
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        reset = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if ({rx_valid, rx_data, frame_err, overrun} !== {exp_valid, exp_data, exp_ferr, exp_ovr}) begin
            failures++;
            $display("FAIL reset_mid: got v/d/fe/ov=%0b/%02h/%0b/%0b want %0b/%02h/%0b/%0b",
                     rx_valid, rx_data, frame_err, overrun, exp_valid, exp_data, exp_ferr, exp_ovr);
        end
        send_frame(8'h12, 1'b1);
        model_frame(8'h12, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if ({rx_valid, rx_data, frame_err, overrun} !== {exp_valid, exp_data, exp_ferr, exp_ovr}) begin
            failures++;
            $display("FAIL after_reset_12: got v/d/fe/ov=%0b/%02h/%0b/%0b want %0b/%02h/%0b/%0b",
                     rx_valid, rx_data, frame_err, overrun, exp_valid, exp_data, exp_ferr, exp_ovr);
        end
    endtask

    // The byte is loaded on the 98th rising edge after the start-bit fall.
    task automatic test_ack_at_load();
        logic [7:0] b1;
        logic [7:0] b2;
        b1 = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        send_frame(b1, 1'b1);
        model_frame(b1, 1'b1, 1'b0);
        fork
            send_frame(b2, 1'b1);
            begin
                repeat (97) @(posedge clk);
                @(negedge clk);
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
            end
        join
        model_frame(b2, 1'b1, 1'b1);
        checks++;
        if ({rx_valid, rx_data, frame_err, overrun} !== {exp_valid, exp_data, exp_ferr, exp_ovr}) begin
            failures++;
            $display("FAIL ack_at_load: got v/d/fe/ov=%0b/%02h/%0b/%0b want %0b/%02h/%0b/%0b",
                     rx_valid, rx_data, frame_err, overrun, exp_valid, exp_data, exp_ferr, exp_ovr);
        end
        pulse_ack();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       stop;
        for (int k = 0; k < 12; k++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) pulse_ack();
            if ($urandom_range(0, 3) == 0) pulse_clr();
            send_frame(b, stop);
            model_frame(b, stop, 1'b0);
            repeat ($urandom_range(5, 12)) @(negedge clk);
            checks++;
            if ({rx_valid, rx_data, frame_err, overrun} !== {exp_valid, exp_data, exp_ferr, exp_ovr}) begin
                failures++;
                $display("FAIL random_%0d: got v/d/fe/ov=%0b/%02h/%0b/%0b want %0b/%02h/%0b/%0b", k,
                         rx_valid, rx_data, frame_err, overrun, exp_valid, exp_data, exp_ferr, exp_ovr);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_reset_midframe();
        pulse_ack();
        test_ack_at_load();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
